// File: rtl/best_weight_store_pkg.sv
// rtl/best_weight_store_pkg.sv - shared defaults, error reset constant and state type for best_weight_store
package best_weight_store_pkg;
    localparam int DEF_BIT_WIDTH   = 32;
    localparam int DEF_EXTRA_BIT   = 2;
    localparam int DEF_NUM_WEIGHTS = 16;
    localparam int DEF_ADDR_WIDTH  = 4;
    localparam int DEF_ERR_WIDTH   = 34;

    // Wide enough for any supported ERR_WIDTH; the top slices off what it needs.
    localparam int                       MAX_ERR_WIDTH = 64;
    localparam logic [MAX_ERR_WIDTH-1:0] ERR_ALL_ONES  = '1;

    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_TRACKING = 1'b1
    } store_state_t;
endpackage

// File: rtl/best_weight_store_weight_bank.sv
// rtl/best_weight_store_weight_bank.sv - single-port RAM, synchronous write, registered read
module best_weight_store_weight_bank #(
    parameter int DATA_WIDTH = 34,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]      w_idx;

    // Callers gate i_we and mask o_rdata for addresses beyond DEPTH.
    assign w_idx = i_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_idx] <= i_wdata;
        end
        o_rdata <= r_mem[w_idx];
    end
endmodule

// File: rtl/best_weight_store.sv
// rtl/best_weight_store.sv - double-banked best-so-far weight store with commit-by-bank-swap
module best_weight_store
    import best_weight_store_pkg::*;
#(
    parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int EXTRA_BIT   = DEF_EXTRA_BIT,
    parameter int NUM_WEIGHTS = DEF_NUM_WEIGHTS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int ERR_WIDTH   = DEF_ERR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           w_valid,
    input  logic [ADDR_WIDTH-1:0]          w_addr,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] w_data,
    input  logic                           epoch_done,
    input  logic [ERR_WIDTH-1:0]           epoch_error,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0] BEST_WEIGHT,
    output logic                           best_valid,
    output logic [ERR_WIDTH-1:0]           best_error,
    output logic                           commit,
    output logic                           reject,
    output logic [15:0]                    epoch_count
);
    localparam int                     DW       = BIT_WIDTH + EXTRA_BIT;
    localparam logic [ADDR_WIDTH:0]    NW_LIMIT = (ADDR_WIDTH + 1)'(NUM_WEIGHTS);
    localparam logic [NUM_WEIGHTS-1:0] MASK_ONE = NUM_WEIGHTS'(1);

    store_state_t            r_state, w_state_next;
    logic                    r_best_bank;
    logic [NUM_WEIGHTS-1:0]  r_mask;
    logic [ERR_WIDTH-1:0]    r_best_error;
    logic                    r_commit, r_reject;
    logic [15:0]             r_epoch_count;
    logic                    r_rd_sel, r_rd_zero;

    logic                    w_wr_en, w_rd_in_range;
    logic [NUM_WEIGHTS-1:0]  w_mask_next;
    logic                    w_complete, w_better, w_do_commit;
    logic                    w_we_a, w_we_b;
    logic [ADDR_WIDTH-1:0]   w_addr_a, w_addr_b;
    logic [DW-1:0]           w_rdata_a, w_rdata_b;

    assign w_wr_en       = w_valid && ({1'b0, w_addr} < NW_LIMIT) && !rst;
    assign w_rd_in_range = {1'b0, rd_addr} < NW_LIMIT;

    // A write in the closing cycle still counts toward completeness.
    assign w_mask_next = r_mask | (w_wr_en ? (MASK_ONE << w_addr) : '0);
    assign w_complete  = &w_mask_next;
    assign w_better    = (r_state == ST_EMPTY) || (epoch_error < r_best_error);
    assign w_do_commit = epoch_done && w_complete && w_better;

    // Committed bank serves reads; the other bank (shadow) takes writes.
    assign w_we_a   = w_wr_en &&  r_best_bank;
    assign w_we_b   = w_wr_en && !r_best_bank;
    assign w_addr_a = r_best_bank ? w_addr : rd_addr;
    assign w_addr_b = r_best_bank ? rd_addr : w_addr;

    best_weight_store_weight_bank #(
        .DATA_WIDTH (DW),
        .DEPTH      (NUM_WEIGHTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank_a (
        .clk     (clk),
        .i_we    (w_we_a),
        .i_addr  (w_addr_a),
        .i_wdata (w_data),
        .o_rdata (w_rdata_a)
    );

    best_weight_store_weight_bank #(
        .DATA_WIDTH (DW),
        .DEPTH      (NUM_WEIGHTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank_b (
        .clk     (clk),
        .i_we    (w_we_b),
        .i_addr  (w_addr_b),
        .i_wdata (w_data),
        .o_rdata (w_rdata_b)
    );

    always_comb begin
        w_state_next = r_state;
        if (w_do_commit) begin
            w_state_next = ST_TRACKING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_EMPTY;
            r_best_bank   <= 1'b0;
            r_mask        <= '0;
            r_best_error  <= ERR_ALL_ONES[ERR_WIDTH-1:0];
            r_commit      <= 1'b0;
            r_reject      <= 1'b0;
            r_epoch_count <= '0;
            r_rd_sel      <= 1'b0;
            r_rd_zero     <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_commit  <= w_do_commit;
            r_reject  <= epoch_done && !w_do_commit;
            // Bank data was read with the pre-swap pointer, so tag it likewise.
            r_rd_sel  <= r_best_bank;
            r_rd_zero <= (r_state == ST_EMPTY) || !w_rd_in_range;
            if (epoch_done) begin
                r_mask <= '0;
                if (r_epoch_count != 16'hFFFF) begin
                    r_epoch_count <= r_epoch_count + 16'd1;
                end
            end else begin
                r_mask <= w_mask_next;
            end
            if (w_do_commit) begin
                r_best_bank  <= ~r_best_bank;
                r_best_error <= epoch_error;
            end
        end
    end

    assign BEST_WEIGHT = r_rd_zero ? '0 : (r_rd_sel ? w_rdata_b : w_rdata_a);
    assign best_valid  = (r_state == ST_TRACKING);
    assign best_error  = r_best_error;
    assign commit      = r_commit;
    assign reject      = r_reject;
    assign epoch_count = r_epoch_count;
endmodule
